// File: rtl/dm_pkg.sv
// dm_pkg: shared widths, constants and entry type for the data-memory store buffer
package dm_pkg;
    localparam int WORD_W  = 32;
    localparam int BE_W    = 4;
    localparam int WADDR_W = 30;
    localparam logic [BE_W-1:0] BE_FULL = 4'hF;
    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [WORD_W-1:0]  data;
        logic [BE_W-1:0]    be;
        logic [WORD_W-1:0]  pc;
    } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// sb_match: age-priority comparator picking the youngest valid entry whose word address matches
// Ports: waddr_i (per-entry word addresses), valid_i (valid mask), rd_ptr_i (oldest slot),
//        ld_waddr_i (load word address) -> match_o, idx_o (youngest matching slot)
module sb_match
    import dm_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [WADDR_W-1:0] waddr_i [DEPTH],
    input  logic [DEPTH-1:0]   valid_i,
    input  logic [PTR_W-1:0]   rd_ptr_i,
    input  logic [WADDR_W-1:0] ld_waddr_i,
    output logic               match_o,
    output logic [PTR_W-1:0]   idx_o
);
    logic [PTR_W-1:0] age, best;
    // age is distance from the oldest slot; wraps for free since DEPTH is a power of two
    always_comb begin
        match_o = 1'b0;
        idx_o   = '0;
        best    = '0;
        age     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = PTR_W'(i) - rd_ptr_i;
            if (valid_i[i] && waddr_i[i] == ld_waddr_i && (!match_o || age >= best)) begin
                match_o = 1'b1;
                idx_o   = PTR_W'(i);
                best    = age;
            end
        end
    end
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write FIFO to data memory with full-word store-to-load forwarding
// Ports: st_* store push (st_ready back-pressure), ld_* combinational load lookup
//        (ld_hit/ld_data forward, ld_stall on partial alias), dm_* head write to DM.
// Build option: STORE_BUF_TRACE_EN prints one trace line per retired store.
module dm_store_buffer
    import dm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [WORD_W-1:0] st_addr,
    input  logic [WORD_W-1:0] st_data,
    input  logic [BE_W-1:0]   st_be,
    input  logic [WORD_W-1:0] st_pc,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [WORD_W-1:0] ld_data,
    output logic              ld_stall,
    output logic              dm_we,
    output logic [WORD_W-1:0] dm_addr,
    output logic [WORD_W-1:0] dm_data,
    output logic [BE_W-1:0]   dm_be,
    output logic [WORD_W-1:0] dm_pc,
    input  logic              dm_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);
    sb_entry_t          mem_q [DEPTH];
    sb_entry_t          head, hit_e;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, hit_idx;
    logic [PTR_W:0]     count_q, count_d;
    logic [DEPTH-1:0]   valid;
    logic [WADDR_W-1:0] waddrs [DEPTH];
    logic               push, pop, match, unused_ok;
    assign unused_ok = ^{st_addr[1:0], ld_addr[1:0]};
    assign head      = mem_q[rd_ptr_q];
    assign hit_e     = mem_q[hit_idx];
    // outputs are forced to their idle values while reset is held
    assign st_ready  = reset || count_q != FULL;
    assign dm_we     = !reset && count_q != '0;
    assign push      = !reset && st_valid && count_q != FULL;
    assign pop       = dm_we && dm_ready;
    assign dm_addr   = {head.waddr, 2'b00};
    assign dm_data   = head.data;
    assign dm_be     = head.be;
    assign dm_pc     = head.pc;
    assign ld_hit    = !reset && ld_valid && match && hit_e.be == BE_FULL;
    assign ld_stall  = !reset && ld_valid && match && hit_e.be != BE_FULL;
    assign ld_data   = ld_hit ? hit_e.data : '0;
    // an entry is live if its distance from the head is below count
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]  = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
            waddrs[i] = mem_q[i].waddr;
        end
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = (push && !pop) ? count_q + ONE : (!push && pop) ? count_q - ONE : count_q;
    end
    sb_match #(.DEPTH(DEPTH)) u_match (
        .waddr_i    (waddrs),
        .valid_i    (valid),
        .rd_ptr_i   (rd_ptr_q),
        .ld_waddr_i (ld_addr[31:2]),
        .match_o    (match),
        .idx_o      (hit_idx)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{waddr: st_addr[31:2], data: st_data, be: st_be, pc: st_pc};
    end
`ifdef STORE_BUF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && pop) $display("@%h: *%h <= %h", dm_pc, dm_addr, dm_data);
    end
`else
`endif
endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0, ld_valid = 1'b0, dm_ready = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0, st_pc = '0, ld_addr = '0;
    logic [3:0]  st_be = '0;
    logic        st_ready, ld_hit, ld_stall, dm_we;
    logic [31:0] ld_data, dm_addr, dm_data, dm_pc;
    logic [3:0]  dm_be;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data), .dm_be(dm_be), .dm_pc(dm_pc),
        .dm_ready(dm_ready)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } st_t;
    typedef struct packed {
        logic        rdy;
        logic        we;
        logic        hit;
        logic        stall;
        logic [31:0] ld;
    } exp_t;

    st_t  model[$];
    st_t  wr_q[$];
    exp_t cyc_q[$];
    int   total = 0, passed = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    // One clock cycle of stimulus; the reference model decides expected outputs and retirements.
    task automatic cyc(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sbe, input logic [31:0] spc,
                       input logic lv, input logic [31:0] la, input logic dr);
        exp_t e;
        st_t  s;
        @(posedge clk);
        #1;
        reset = r; st_valid = sv; st_addr = sa; st_data = sd; st_be = sbe; st_pc = spc;
        ld_valid = lv; ld_addr = la; dm_ready = dr;
        e = '0;
        if (r) begin
            e.rdy = 1'b1;
            cyc_q.push_back(e);
            model.delete();
            wr_q.delete();
        end else begin
            e.rdy = model.size() < DEPTH;
            e.we  = model.size() != 0;
            if (lv) begin
                for (int i = model.size() - 1; i >= 0; i--) begin
                    if (model[i].addr[31:2] == la[31:2]) begin
                        e.hit   = model[i].be == 4'hF;
                        e.stall = model[i].be != 4'hF;
                        e.ld    = e.hit ? model[i].data : 32'h0;
                        break;
                    end
                end
            end
            cyc_q.push_back(e);
            if (e.we && dr) void'(model.pop_front());
            if (sv && e.rdy) begin
                s = '{addr: {sa[31:2], 2'b00}, data: sd, be: sbe, pc: spc};
                model.push_back(s);
                wr_q.push_back(s);
            end
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] pc, input logic dr);
        cyc(1'b0, 1'b1, a, d, be, pc, 1'b0, 32'h0, dr);
    endtask

    task automatic idle(input logic lv, input logic [31:0] la, input logic dr);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, lv, la, dr);
    endtask

    // Monitor: mid-cycle, compare DUT outputs with the expectation queued for this cycle and
    // match every DM write against the next store in program order.
    always @(negedge clk) begin
        exp_t e;
        st_t  s;
        if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            chk("st_ready", 32'(st_ready), 32'(e.rdy));
            chk("dm_we", 32'(dm_we), 32'(e.we));
            chk("ld_hit", 32'(ld_hit), 32'(e.hit));
            chk("ld_stall", 32'(ld_stall), 32'(e.stall));
            chk("ld_data", ld_data, e.ld);
            if (dm_we && dm_ready && !reset) begin
                if (wr_q.size() == 0) begin
                    total++;
                    $display("FAIL dm_write_unexpected: got write to %h expected no write", dm_addr);
                end else begin
                    s = wr_q.pop_front();
                    chk("dm_addr", dm_addr, s.addr);
                    chk("dm_data", dm_data, s.data);
                    chk("dm_be", 32'(dm_be), 32'(s.be));
                    chk("dm_pc", dm_pc, s.pc);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  be;
        logic        rr;
        repeat (2) cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (5) idle(1'b0, 32'h0, 1'b0);
        idle(1'b1, 32'h10, 1'b0);
        push(32'h10, 32'hDEAD_BEEF, 4'hF, 32'h100, 1'b0);
        idle(1'b1, 32'h10, 1'b0);
        idle(1'b0, 32'h0, 1'b1);
        idle(1'b1, 32'h10, 1'b0);
        for (int i = 0; i < 5; i++) push(32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 32'h200 + 32'(4 * i), 1'b0);
        push(32'h60, 32'hBAD0_0000, 4'hF, 32'h300, 1'b1);
        idle(1'b1, 32'h4C, 1'b0);
        repeat (3) idle(1'b0, 32'h0, 1'b1);
        push(32'h20, 32'h1111_1111, 4'hF, 32'h400, 1'b0);
        push(32'h20, 32'h2222_2222, 4'hF, 32'h404, 1'b0);
        idle(1'b1, 32'h22, 1'b0);
        idle(1'b1, 32'h20, 1'b1);
        idle(1'b1, 32'h21, 1'b1);
        push(32'h30, 32'h0000_5555, 4'b0011, 32'h500, 1'b0);
        idle(1'b1, 32'h30, 1'b0);
        idle(1'b1, 32'h30, 1'b1);
        idle(1'b1, 32'h30, 1'b0);
        push(32'h34, 32'h0, 4'h0, 32'h504, 1'b0);
        idle(1'b1, 32'h34, 1'b1);
        for (int i = 0; i < 9; i++) push(32'h80 + 32'(4 * (i % 3)), 32'hC000_0000 + 32'(i), 4'hF, 32'h600 + 32'(4 * i), 1'(i % 2));
        repeat (6) idle(1'b1, 32'h84, 1'b1);
        for (int i = 0; i < 3; i++) push(32'h90 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'hF, 32'h700 + 32'(4 * i), 1'b0);
        cyc(1'b1, 1'b1, 32'h90, 32'h1, 4'hF, 32'h0, 1'b1, 32'h90, 1'b1);
        idle(1'b1, 32'h90, 1'b1);
        idle(1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            a  = 32'h40 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            rr = $urandom_range(0, 99) == 0;
            cyc(rr, 1'($urandom), a, $urandom, be, $urandom, 1'($urandom),
                32'h40 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3)),
                $urandom_range(0, 2) != 0);
        end
        for (int n = 0; n < 20 && wr_q.size() != 0; n++) idle(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #1;
        total++;
        if (wr_q.size() == 0) passed++;
        else $display("FAIL drain_timeout: got %0d stores still pending expected 0", wr_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write FIFO between the datapath's memory-access logic and the data memory (DM).
- Accepts stores (address, data, byte enables, PC), retires them to DM one per cycle when DM signals ready, and forwards buffered full-word store data to younger loads.
- Partial-word hits (load aliases a buffered store with incomplete byte enables) stall the load until that store drains.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- st_valid  in  1  store request.
- st_addr  in  32  store byte address; bits [1:0] ignored.
- st_data  in  32  store data, already lane-aligned.
- st_be  in  4  byte enables; bit i covers data[8i+7:8i].
- st_pc  in  32  PC of the store instruction, for trace.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load lookup request.
- ld_addr  in  32  load byte address; bits [1:0] ignored.
- ld_hit  out  1  forwarding hit; ld_data is valid.
- ld_data  out  32  forwarded word.
- ld_stall  out  1  partial alias; load must retry.
- dm_we  out  1  head entry valid, write requested.
- dm_addr  out  32  head address, {addr[31:2],2'b00}.
- dm_data  out  32  head data.
- dm_be  out  4  head byte enables.
- dm_pc  out  32  head PC.
- dm_ready  in  1  DM accepts the write this cycle.

Behaviour:
- Reset (already decided): reset is synchronous, active-high; clock is clk.
- Reset clears rd_ptr, wr_ptr and count. Entry contents are don't-care.
- Values during and immediately after reset: st_ready=1, dm_we=0, ld_hit=0, ld_stall=0, ld_data=0.
- Reset mid-drain discards all pending stores. No DM write occurs in the reset cycle.
- Storage: circular array of DEPTH entries {addr[31:2], data, be, pc}, plus a count of 0..DEPTH.
- Push: on st_valid && st_ready, write the entry at wr_ptr, then wr_ptr++ (wraps modulo DEPTH).
  - st_ready = (count != DEPTH). There is no same-cycle bypass when full.
  - st_be == 0 is accepted and drained like any other store.
- Pop: dm_we = (count != 0), and dm_* show the head entry combinationally.
  - On dm_we && dm_ready, rd_ptr++ (wraps).
  - Head output is stable while dm_ready is low.
- Push and pop in the same cycle leave count unchanged.
- Latency: a store pushed at edge N is visible on dm_* after edge N if the buffer was empty. Store-to-DM-write latency is therefore 1 cycle minimum.
- Load lookup is combinational and active only when ld_valid=1; otherwise all ld_* outputs are 0.
  - Compare ld_addr[31:2] against every valid entry, including the head being popped this cycle.
  - Select the youngest match (closest to wr_ptr).
  - Youngest match has be == 4'hF: ld_hit=1, ld_data = entry data, ld_stall=0.
  - Youngest match has be != 4'hF: ld_stall=1, ld_hit=0, ld_data=0.
  - No match: ld_hit=0, ld_stall=0, ld_data=0; the caller reads DM.
  - A store being pushed in the same cycle is not visible to the lookup.
- Program order: FIFO order is preserved. No merging, no reordering.

Optional Feature:
- Macro: STORE_BUF_TRACE_EN.
- Defined: on each pop (dm_we && dm_ready at posedge clk, reset low), emit $display("@%h: *%h <= %h", dm_pc, dm_addr, dm_data).
- Undefined: no display statements are compiled. Functional behaviour is identical.

Decomposition:
- Package dm_pkg holds:
  - WORD_W=32, BE_W=4, WADDR_W=30.
  - BE_FULL=4'hF.
  - typedef sb_entry_t {waddr, data, be, pc}.
- Sub-module sb_match: age-priority comparator.
  - Inputs: entries, valid mask, rd_ptr, ld waddr.
  - Outputs: match, youngest index.
- FIFO control stays in dm_store_buffer.

Test Plan:
- Reset then idle -> st_ready=1, dm_we=0, ld_hit=0, ld_stall=0 for 5 cycles.
- Push 0x0000_0010/0xDEAD_BEEF/be=F with dm_ready=0 -> next cycle dm_we=1, dm_addr=0x10, dm_data=0xDEADBEEF. Raise dm_ready -> count 0 next cycle.
- Push 4 stores with dm_ready=0 -> st_ready=0. 5th st_valid is ignored. Simultaneous push/pop at full -> push refused, count=3.
- Push 0x20=0x1111_1111 (be=F), then 0x20=0x2222_2222 (be=F); ld_addr=0x22 -> ld_hit=1, ld_data=0x22222222 (youngest wins).
- Push 0x30/be=4'b0011; ld_addr=0x30 -> ld_stall=1. Drain with dm_ready=1 -> next cycle ld_stall=0, ld_hit=0.
- Fill and drain 9 stores across pointer wrap with STORE_BUF_TRACE_EN defined -> 9 trace lines in push order, matching PCs.
